// File: rtl/vdg_video_fetch.sv
// rtl/vdg_video_fetch.sv - video RAM address generator and fetch pipeline for the VDG
// Follows DA0/HSn/FSn and replays each row for every scanline of a character or pixel row.
module vdg_video_fetch #(
   parameter int ADDR_W = 16,
   parameter int RD_LAT = 2
) (
   input  logic              Clk,
   input  logic              RSTn,
   input  logic              DA0,
   input  logic              HSn,
   input  logic              FSn,
   input  logic [2:0]        VMode,
   input  logic [6:0]        Offset,
   input  logic [7:0]        MemData,
   output logic              RdReq,
   output logic [ADDR_W-1:0] VAddr,
   output logic [7:0]        Data,
   output logic              DataValid
);

   // [0],[1] synchronizer stages, [2] previous value for edge detection
   logic [2:0] da_sr, hs_sr, fs_sr;
   logic       da_rise, hs_fall, fs_fall;

   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] row_q, row_d;
   logic [3:0]        line_q, line_d;
   logic [5:0]        byte_q, byte_d;
   logic [2:0]        mode_q, mode_d;
   logic [5:0]        row_w;
   logic [3:0]        row_r;
   logic              issue;
   logic [RD_LAT-1:0] vld_sr;

   always_ff @(posedge Clk or negedge RSTn) begin
      if (!RSTn) begin
         da_sr <= 3'b000;
         hs_sr <= 3'b111;
         fs_sr <= 3'b111;
      end else begin
         da_sr <= {da_sr[1:0], DA0};
         hs_sr <= {hs_sr[1:0], HSn};
         fs_sr <= {fs_sr[1:0], FSn};
      end
   end

   assign da_rise = da_sr[1] & ~da_sr[2];
   assign hs_fall = ~hs_sr[1] & hs_sr[2];
   assign fs_fall = ~fs_sr[1] & fs_sr[2];

   always_comb begin
      row_w = 6'd32;
      row_r = 4'd1;
      case (mode_q)
         3'd0: begin row_w = 6'd32; row_r = 4'd12; end
         3'd1: begin row_w = 6'd16; row_r = 4'd3;  end
         3'd2: begin row_w = 6'd32; row_r = 4'd3;  end
         3'd3: begin row_w = 6'd16; row_r = 4'd2;  end
         3'd4: begin row_w = 6'd32; row_r = 4'd2;  end
         3'd5: begin row_w = 6'd16; row_r = 4'd1;  end
         default: begin row_w = 6'd32; row_r = 4'd1; end
      endcase
   end

   // Event priority: field sync, then line sync, then fetch strobe (dropped if it loses)
   always_comb begin
      addr_d = addr_q;
      row_d  = row_q;
      line_d = line_q;
      byte_d = byte_q;
      mode_d = mode_q;
      issue  = 1'b0;
      if (fs_fall) begin
         mode_d = VMode;
         row_d  = ADDR_W'({Offset, 9'b0});
         addr_d = ADDR_W'({Offset, 9'b0});
         line_d = 4'd0;
         byte_d = 6'd0;
      end else if (hs_fall) begin
         byte_d = 6'd0;
         if (line_q == row_r - 4'd1) begin
            line_d = 4'd0;
            row_d  = row_q + ADDR_W'(row_w);
            addr_d = row_q + ADDR_W'(row_w);
         end else begin
            line_d = line_q + 4'd1;
            addr_d = row_q;
         end
      end else if (da_rise && (byte_q < row_w)) begin
         issue  = 1'b1;
         addr_d = addr_q + 1'b1;
         byte_d = byte_q + 6'd1;
      end
   end

   always_ff @(posedge Clk or negedge RSTn) begin
      if (!RSTn) begin
         addr_q <= '0;
         row_q  <= '0;
         line_q <= 4'd0;
         byte_q <= 6'd0;
         mode_q <= 3'd0;
      end else begin
         addr_q <= addr_d;
         row_q  <= row_d;
         line_q <= line_d;
         byte_q <= byte_d;
         mode_q <= mode_d;
      end
   end

   // vld_sr[0] is the request strobe itself; the last tap marks the cycle MemData is valid
   always_ff @(posedge Clk or negedge RSTn) begin
      if (!RSTn) begin
         vld_sr    <= '0;
         VAddr     <= '0;
         Data      <= 8'd0;
         DataValid <= 1'b0;
      end else begin
         vld_sr[0] <= issue;
         for (int i = 1; i < RD_LAT; i++) begin
            vld_sr[i] <= vld_sr[i-1];
         end
         if (issue) begin
            VAddr <= addr_q;
         end
         DataValid <= vld_sr[RD_LAT-1];
         if (vld_sr[RD_LAT-1]) begin
            Data <= MemData;
         end
      end
   end

   assign RdReq = vld_sr[0];

endmodule

// File: tb/tb_vdg_video_fetch.sv
// tb/tb_vdg_video_fetch.sv - self-checking bench for vdg_video_fetch
// Row/line arithmetic model plus a per-cycle monitor and a latency-delayed memory responder.
module tb_vdg_video_fetch;

   logic        Clk = 1'b0;
   logic        RSTn = 1'b0;
   logic        DA0 = 1'b0;
   logic        HSn = 1'b1;
   logic        FSn = 1'b1;
   logic [2:0]  VMode = 3'd0;
   logic [6:0]  Offset = 7'd0;
   logic [7:0]  MemData = 8'd0;
   logic        RdReq;
   logic [15:0] VAddr;
   logic [7:0]  Data;
   logic        DataValid;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int req_cnt = 0;
   int dv_cnt = 0;

   int m_base, m_w, m_r, m_hs, m_byte;
   logic [15:0] exp_q[$];
   logic [7:0]  dq[$];
   int          cq[$];
   logic [15:0] log_addr[$];
   logic [7:0]  log_data[$];
   logic [7:0]  last_data = 8'd0;
   logic        prev_req = 1'b0;
   logic [15:0] prev_addr = 16'd0;

   vdg_video_fetch #(.ADDR_W(16), .RD_LAT(2)) dut (
      .Clk(Clk), .RSTn(RSTn), .DA0(DA0), .HSn(HSn), .FSn(FSn),
      .VMode(VMode), .Offset(Offset), .MemData(MemData),
      .RdReq(RdReq), .VAddr(VAddr), .Data(Data), .DataValid(DataValid)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string nm, input longint act, input longint exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic int mode_w(input int m);
      return (m == 1 || m == 3 || m == 5) ? 16 : 32;
   endfunction

   function automatic int mode_r(input int m);
      case (m)
         0: return 12;
         1, 2: return 3;
         3, 4: return 2;
         default: return 1;
      endcase
   endfunction

   function automatic logic [15:0] model_addr();
      return 16'((m_base + (m_hs / m_r) * m_w + m_byte) % 65536);
   endfunction

   task automatic model_reset();
      m_base = 0; m_w = 32; m_r = 12; m_hs = 0; m_byte = 0;
      exp_q.delete(); dq.delete(); cq.delete();
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge Clk);
      #2;
   endtask

   task automatic model_fs(input int m, input int off);
      m_base = off * 512; m_w = mode_w(m); m_r = mode_r(m); m_hs = 0; m_byte = 0;
   endtask

   task automatic fs_event(input int m, input int off);
      VMode = 3'(m); Offset = 7'(off); FSn = 1'b0;
      model_fs(m, off);
      tick(3); FSn = 1'b1; tick(3);
   endtask

   task automatic hs_event();
      HSn = 1'b0; m_hs++; m_byte = 0;
      tick(3); HSn = 1'b1; tick(3);
   endtask

   task automatic pulse(input int hi, input int lo);
      DA0 = 1'b1;
      if (m_byte < m_w) begin
         exp_q.push_back(model_addr());
         m_byte++;
      end
      tick(hi); DA0 = 1'b0; tick(lo);
   endtask

   task automatic pulses(input int n, input int hi, input int lo);
      repeat (n) pulse(hi, lo);
   endtask

   // Monitor + memory responder: data for a request is presented two edges after RdReq
   always @(negedge Clk) begin
      cyc++;
      if (!RSTn) begin
         chk("reset_outputs", {RdReq, DataValid, VAddr, Data}, 0);
         last_data = 8'd0;
      end else begin
         if (RdReq) begin
            req_cnt++;
            if (exp_q.size() == 0) chk("unexpected_rdreq", VAddr, 16'hxxxx === 16'h0 ? 0 : 1'b1 ^ 1'b1 + 32'hFFFF_FFFF);
            else chk("vaddr", VAddr, exp_q.pop_front());
            log_addr.push_back(VAddr);
            dq.push_back(VAddr[7:0] ^ 8'hA5);
            cq.push_back(cyc);
         end
         if (DataValid) begin
            dv_cnt++;
            if (dq.size() == 0) begin
               chk("unexpected_datavalid", DataValid, 0);
            end else begin
               chk("data", Data, dq.pop_front());
               chk("dv_latency", cyc - cq.pop_front(), 2);
            end
            log_data.push_back(Data);
            last_data = Data;
         end else begin
            chk("data_hold", Data, last_data);
         end
      end
      MemData = prev_req ? (prev_addr[7:0] ^ 8'hA5) : 8'($urandom);
      prev_req = RdReq;
      prev_addr = VAddr;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int j, d, n, dv0;
      logic ok;
      model_reset();

      // Reset with wiggling inputs, then release with idle inputs
      RSTn = 1'b0;
      repeat (6) begin
         DA0 = 1'($urandom); HSn = 1'($urandom); FSn = 1'($urandom);
         VMode = 3'($urandom); Offset = 7'($urandom);
         tick(1);
      end
      DA0 = 1'b0; HSn = 1'b1; FSn = 1'b1;
      tick(2);
      RSTn = 1'b1;
      model_reset();
      tick(10);
      chk("idle_rdreq_cnt", req_cnt, 0);
      chk("idle_dv_cnt", dv_cnt, 0);

      // Alpha frame: 12-line rows at base 0x0400
      fs_event(0, 2);
      j = log_addr.size();
      d = log_data.size();
      DA0 = 1'b1;
      exp_q.push_back(model_addr());
      m_byte++;
      n = 0; ok = 1'b0;
      for (int i = 0; i < 8 && !ok; i++) begin
         @(posedge Clk); #1; n++;
         if (RdReq) ok = 1'b1;
      end
      chk("da_to_rdreq_edges", n, 3);
      tick(2); DA0 = 1'b0; tick(2);
      pulses(31, 2, 2);
      for (int l = 1; l <= 12; l++) begin
         hs_event();
         pulses(l == 12 ? 4 : 32, 2, 2);
      end
      tick(6);
      chk("alpha_first", log_addr[j], 16'h0400);
      chk("alpha_last_byte", log_addr[j+31], 16'h041F);
      chk("alpha_line11_first", log_addr[j+11*32], 16'h0400);
      chk("alpha_line11_last", log_addr[j+11*32+31], 16'h041F);
      chk("alpha_row1_first", log_addr[j+12*32], 16'h0420);
      chk("alpha_first_data", log_data[d], 8'hA5);

      // Mode 5, 20 fast pulses per line, only 16 fetches each
      fs_event(5, 0);
      j = log_addr.size();
      for (int l = 0; l < 4; l++) begin
         if (l > 0) hs_event();
         pulses(20, 1, 1);
      end
      tick(6);
      chk("m5_req_count", log_addr.size() - j, 64);
      chk("m5_line2_first", log_addr[j+32], 16'h0020);
      chk("m5_line3_last", log_addr[j+63], 16'h003F);

      // Coincident fs+hs: base applied, no row advance
      VMode = 3'd6; Offset = 7'h10; FSn = 1'b0; HSn = 1'b0;
      model_fs(6, 16);
      tick(3); FSn = 1'b1; HSn = 1'b1; tick(3);
      j = log_addr.size();
      pulses(4, 2, 2);
      hs_event();
      pulses(2, 2, 2);
      // Coincident da+hs: line advances, strobe dropped
      DA0 = 1'b1; HSn = 1'b0; m_hs++; m_byte = 0;
      tick(3); DA0 = 1'b0; HSn = 1'b1; tick(3);
      pulse(2, 2);
      tick(6);
      chk("fshs_base", log_addr[j], 16'h2000);
      chk("fshs_next_line", log_addr[j+4], 16'h2020);
      chk("dahs_next_line", log_addr[j+6], 16'h2040);
      chk("dahs_req_count", log_addr.size() - j, 7);

      // Address wrap at the top of memory
      fs_event(6, 7'h7F);
      j = log_addr.size();
      for (int l = 0; l < 16; l++) begin
         if (l > 0) hs_event();
         pulses(32, 1, 1);
      end
      hs_event();
      pulses(2, 2, 2);
      tick(6);
      chk("wrap_first", log_addr[j], 16'hFE00);
      chk("wrap_top", log_addr[j+511], 16'hFFFF);
      chk("wrap_zero", log_addr[j+512], 16'h0000);

      // Reset while a read is in flight
      DA0 = 1'b1;
      exp_q.push_back(model_addr());
      ok = 1'b0;
      for (int i = 0; i < 8 && !ok; i++) begin
         @(posedge Clk); #1;
         if (RdReq) ok = 1'b1;
      end
      chk("midrst_req_seen", ok, 1);
      dv0 = dv_cnt;
      RSTn = 1'b0;
      DA0 = 1'b0;
      model_reset();
      tick(3);
      RSTn = 1'b1;
      tick(10);
      chk("midrst_no_stale_dv", dv_cnt, dv0);

      // Recovery after reset
      fs_event(1, 3);
      j = log_addr.size();
      d = log_data.size();
      pulse(2, 2);
      tick(6);
      chk("recover_addr", log_addr[j], 16'h0600);
      chk("recover_data", log_data[d], 8'hA5);
      chk("exp_queue_drained", exp_q.size(), 0);
      chk("data_queue_drained", dq.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/vdg_video_fetch.md
Name: vdg_video_fetch

Overview:
- Memory-side counterpart to the VDG pixel pipeline, equivalent to the address-generator role of a 6883 SAM.
- Tracks the VDG's DA0, HSn and FSn outputs and generates the video RAM address sequence for each frame.
- Issues one read request per DA0 pulse, captures the returned byte and presents it on the VDG Data bus.
- Handles per-mode line width and vertical line repeat, so the VDG sees the same row bytes for every scanline of a character or pixel row.

Parameters:
- ADDR_W, 16, video address width.
- RD_LAT, 2, Clk cycles from RdReq to MemData valid (legal range 1..4).

Ports:
- Clk  input  1  system clock; all logic on its rising edge.
- RSTn  input  1  asynchronous active-low reset.
- DA0  input  1  VDG fetch strobe (asynchronous to Clk).
- HSn  input  1  VDG horizontal sync, active low (asynchronous to Clk).
- FSn  input  1  VDG field sync, active low (asynchronous to Clk).
- VMode  input  3  row width / repeat select, sampled at frame start.
- Offset  input  7  display base, address bits [15:9], sampled at frame start.
- MemData  input  8  read data from video RAM.
- RdReq  output  1  one-cycle read strobe.
- VAddr  output  ADDR_W  address accompanying RdReq.
- Data  output  8  byte presented to the VDG.
- DataValid  output  1  one-cycle pulse when Data updates.

Behaviour:
- Reset (async, RSTn low): VAddr=0, Data=0, RdReq=0, DataValid=0. Address counter, RowStart, line counter and byte counter all 0. Latched mode=0, latched base=0. Synchronizers load 1 for HSn/FSn and 0 for DA0.
- Input conditioning: DA0, HSn and FSn each pass through a 2-flop synchronizer plus an edge register. Events used:
  - da_rise: DA0 0->1.
  - hs_fall: HSn 1->0.
  - fs_fall: FSn 1->0.
- Mode table (VMode -> bytes per line W, lines per row R):
  - 0: 32, 12.
  - 1: 16, 3.
  - 2: 32, 3.
  - 3: 16, 2.
  - 4: 32, 2.
  - 5: 16, 1.
  - 6 and 7: 32, 1.
- fs_fall:
  - Latch VMode and Offset.
  - Addr = RowStart = {Offset, 9'b0}.
  - LineCnt = 0; ByteCnt = 0.
- hs_fall (no fs_fall in the same cycle):
  - ByteCnt = 0.
  - If LineCnt == R-1: LineCnt = 0 and RowStart = RowStart + W, with Addr set to the same value.
  - Otherwise: LineCnt++ and Addr = RowStart, replaying the row.
- da_rise (no fs_fall/hs_fall in the same cycle) with ByteCnt < W:
  - Next cycle: RdReq = 1 and VAddr = Addr.
  - Addr++ and ByteCnt++.
- da_rise with ByteCnt == W: ignored. No RdReq, Addr holds, Data holds.
- Priority when events coincide: fs_fall > hs_fall > da_rise. A suppressed da_rise is dropped, not deferred.
- Read pipeline:
  - A RD_LAT-deep valid shift register tracks each RdReq.
  - When the tap matures, Data = MemData and DataValid = 1 for that cycle only.
  - A new request may issue every cycle; returns stay in order.
- Arithmetic: Addr and RowStart wrap modulo 2^ADDR_W (0xFFFF+1 = 0x0000). Counter widths: LineCnt 4 bits, ByteCnt 6 bits.
- Latency: da_rise edge to RdReq is 3 Clk cycles (2 sync + 1 register). RdReq to DataValid is RD_LAT cycles.
- Reset mid-operation: in-flight reads are discarded, so no DataValid occurs after RSTn deasserts until a new RdReq has issued.
- VMode/Offset changes mid-frame have no effect until the next fs_fall.

Test Plan:
- Reset: hold RSTn low with random inputs -> all outputs 0. Release with no input edges -> RdReq and DataValid stay 0.
- Alpha frame: VMode=0, Offset=2, fs_fall, then 12 lines of 32 DA0 pulses each.
  - Every line of rows 0-11 issues VAddr 0x0400..0x041F.
  - The line after the 12th hs_fall starts at 0x0420.
- Mode 5 with extra pulses: VMode=5, Offset=0, 20 DA0 pulses per line.
  - Exactly 16 RdReq per line; line n starts at 16*n.
  - Pulses 17-20 produce no RdReq.
- Coincident events: fs_fall and hs_fall synchronized in the same cycle -> Addr = base, LineCnt = 0, no row advance. da_rise coincident with hs_fall -> no RdReq.
- Wrap: Offset=0x7F, VMode=6, 16 lines of 32 pulses -> addresses run 0xFE00..0xFFFF, then the next request is 0x0000.
- Read return: RD_LAT=2, MemData driven 0xA5 two cycles after RdReq -> Data=0xA5 with a single-cycle DataValid. Back-to-back requests return bytes in order. Asserting RSTn mid-pipeline -> no stale DataValid.
